// File: rtl/button_conditioner_if.sv
// Player-control bundle between the panel inputs and the game logic.
//   button        : push buttons, active-high, asynchronous to clk
//   xsw           : panel switches, active-low, asynchronous to clk
//   repeat_en     : per-channel auto-repeat enable, synchronous to clk
//   level         : debounced pressed state, 1 = pressed
//   press         : one-cycle pulse on level rise or auto-repeat tick
//   release_pulse : one-cycle pulse on level fall
// The master side drives the raw controls; the slave side is the conditioner.
interface button_conditioner_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] xsw;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;

    modport master (
        output button, xsw, repeat_en,
        input  level, press, release_pulse
    );

    modport slave (
        input  button, xsw, repeat_en,
        output level, press, release_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// N-channel player-control front end. Each channel merges an active-high button
// with an active-low panel switch, synchronises and debounces the result, and
// produces a clean level plus registered one-cycle press/release pulses.
// Optional auto-repeat re-fires press while a channel is held.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, clears every flop
//   bus   : button_conditioner_if slave (button/xsw/repeat_en in,
//           level/press/release_pulse out)
module button_conditioner #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned REPEAT_DELAY    = 500,
    parameter int unsigned REPEAT_PERIOD   = 100
) (
    input logic                clk,
    input logic                rst_n,
    button_conditioner_if.slave bus
);
    localparam int unsigned DCNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RCNT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned RCNT_W    = $clog2(RCNT_MAX) + 1;

    // Auto-repeat phase: waiting for the first repeat, or in the steady period.
    localparam logic PH_DELAY  = 1'b0;
    localparam logic PH_PERIOD = 1'b1;

    localparam logic [DCNT_W-1:0] DCNT_LAST    = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LIMIT  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] PERIOD_LIMIT = RCNT_W'(REPEAT_PERIOD);

    logic [N_CH-1:0]        raw;
    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [DCNT_W-1:0]      dcnt_q [N_CH];
    logic [DCNT_W-1:0]      dcnt_d [N_CH];
    logic [RCNT_W-1:0]      rcnt_q [N_CH];
    logic [RCNT_W-1:0]      rcnt_d [N_CH];
    logic [N_CH-1:0]        level_q, level_d;
    logic [N_CH-1:0]        phase_q, phase_d;
    logic [N_CH-1:0]        press_q, press_d;
    logic [N_CH-1:0]        rel_q, rel_d;

    assign raw = bus.button | ~bus.xsw;

    always_comb begin
        logic              sync;
        logic              tick;
        logic [RCNT_W-1:0] limit;
        logic [RCNT_W-1:0] rcnt_inc;
        sync     = 1'b0;
        tick     = 1'b0;
        limit    = '0;
        rcnt_inc = '0;
        level_d  = level_q;
        phase_d  = '0;
        press_d  = '0;
        rel_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            dcnt_d[i] = '0;
            rcnt_d[i] = '0;
        end

        for (int i = 0; i < N_CH; i++) begin
            sync = sync_q[i][SYNC_STAGES-1];

            // Debounce: any sample agreeing with level restarts the count.
            if (sync != level_q[i]) begin
                if (dcnt_q[i] == DCNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                end
            end

            // Auto-repeat only runs while held before and after this edge, so a
            // repeat tick never lands on the rise or fall edge itself.
            tick       = 1'b0;
            phase_d[i] = PH_DELAY;
            limit      = (phase_q[i] == PH_PERIOD) ? PERIOD_LIMIT : DELAY_LIMIT;
            rcnt_inc   = rcnt_q[i] + RCNT_W'(1);
            if (level_q[i] && level_d[i] && bus.repeat_en[i]) begin
                if (rcnt_inc == limit) begin
                    tick       = 1'b1;
                    phase_d[i] = PH_PERIOD;
                end else begin
                    rcnt_d[i]  = rcnt_inc;
                    phase_d[i] = phase_q[i];
                end
            end

            press_d[i] = (level_d[i] & ~level_q[i]) | tick;
            rel_d[i]   = ~level_d[i] & level_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= '0;
                dcnt_q[i] <= '0;
                rcnt_q[i] <= '0;
            end
            level_q <= '0;
            phase_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                dcnt_q[i] <= dcnt_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
            level_q <= level_d;
            phase_q <= phase_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign bus.level         = level_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = rel_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs change 1 time unit after a rising
// edge (call it edge 0); a held change shows on level at the 6th edge after it.
module tb_button_conditioner;
    localparam int unsigned N_CH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    button_conditioner_if #(.N_CH(N_CH)) bus ();

    button_conditioner #(
        .N_CH            (N_CH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks all three output vectors after one edge.
    task automatic step_check(input string tag, input int k, input logic [3:0] lv,
                              input logic [3:0] pr, input logic [3:0] rl);
        tick();
        check($sformatf("%s_level_%0d", tag, k), 32'(bus.level), 32'(lv));
        check($sformatf("%s_press_%0d", tag, k), 32'(bus.press), 32'(pr));
        check($sformatf("%s_rel_%0d", tag, k), 32'(bus.release_pulse), 32'(rl));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        bus.button    = '0;
        bus.xsw       = '1;
        bus.repeat_en = '0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #5;
        check("reset_level", 32'(bus.level), 32'h0);
        check("reset_press", 32'(bus.press), 32'h0);
        check("reset_rel", 32'(bus.release_pulse), 32'h0);
        #16 rst_n = 1'b1;
        tick();

        // 1: idle, then panel switch on channel 1.
        for (int k = 1; k <= 20; k++) step_check("idle", k, 4'h0, 4'h0, 4'h0);
        bus.xsw[1] = 1'b0;
        for (int k = 1; k <= 8; k++)
            step_check("sw1_on", k, (k >= 6) ? 4'h2 : 4'h0, (k == 6) ? 4'h2 : 4'h0, 4'h0);
        bus.xsw[1] = 1'b1;
        for (int k = 1; k <= 8; k++)
            step_check("sw1_off", k, (k < 6) ? 4'h2 : 4'h0, 4'h0, (k == 6) ? 4'h2 : 4'h0);

        // 2: bouncing button never survives the debounce window.
        for (int k = 1; k <= 20; k++) begin
            if (k % 2 == 1) bus.button[0] = ~bus.button[0];
            step_check("bounce", k, 4'h0, 4'h0, 4'h0);
        end
        bus.button[0] = 1'b0;
        for (int k = 1; k <= 8; k++) step_check("bounce_q", k, 4'h0, 4'h0, 4'h0);

        // 3: button and switch overlap on channel 2.
        bus.button[2] = 1'b1;
        for (int k = 1; k <= 8; k++)
            step_check("ovl_on", k, (k >= 6) ? 4'h4 : 4'h0, (k == 6) ? 4'h4 : 4'h0, 4'h0);
        bus.xsw[2] = 1'b0;
        tick();
        bus.button[2] = 1'b0;
        for (int k = 1; k <= 10; k++) step_check("ovl_hold", k, 4'h4, 4'h0, 4'h0);
        bus.xsw[2] = 1'b1;
        for (int k = 1; k <= 8; k++)
            step_check("ovl_off", k, (k < 6) ? 4'h4 : 4'h0, 4'h0, (k == 6) ? 4'h4 : 4'h0);

        // 4a: auto-repeat on channel 3; rise at k=6, repeats at +10, +13, +16, +19.
        bus.repeat_en[3] = 1'b1;
        bus.button[3]    = 1'b1;
        for (int k = 1; k <= 26; k++)
            step_check("rep", k, (k >= 6) ? 4'h8 : 4'h0,
                       (k == 6 || k == 16 || k == 19 || k == 22 || k == 25) ? 4'h8 : 4'h0,
                       4'h0);
        // Still held for 5 more edges, so repeats keep coming at +22 and +25 of rise.
        bus.button[3] = 1'b0;
        for (int k = 1; k <= 10; k++)
            step_check("rep_rel", k, (k < 6) ? 4'h8 : 4'h0,
                       (k == 2 || k == 5) ? 4'h8 : 4'h0, (k == 6) ? 4'h8 : 4'h0);

        // 4b: enable dropped so the edge at rise+12 sees it low.
        bus.button[3] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step_check("rep_dis", k, (k >= 6) ? 4'h8 : 4'h0,
                       (k == 6 || k == 16) ? 4'h8 : 4'h0, 4'h0);
            if (k == 17) bus.repeat_en[3] = 1'b0;
        end
        bus.button[3] = 1'b0;
        for (int k = 1; k <= 8; k++)
            step_check("rep_dis_rel", k, (k < 6) ? 4'h8 : 4'h0, 4'h0, (k == 6) ? 4'h8 : 4'h0);

        // 5: reset mid-hold drops level at once with no release pulse.
        bus.button[0] = 1'b1;
        for (int k = 1; k <= 8; k++)
            step_check("hold0", k, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(bus.level), 32'h0);
        check("async_rst_press", 32'(bus.press), 32'h0);
        check("async_rst_rel", 32'(bus.release_pulse), 32'h0);
        tick();
        check("in_rst_rel", 32'(bus.release_pulse), 32'h0);
        #3 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++)
            step_check("post_rst", k, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0);
        bus.button[0] = 1'b0;
        for (int k = 1; k <= 8; k++)
            step_check("post_rst_rel", k, (k < 6) ? 4'h1 : 4'h0, 4'h0, (k == 6) ? 4'h1 : 4'h0);

        // 6: channels 0 and 3 pressed together.
        bus.button[0] = 1'b1;
        bus.button[3] = 1'b1;
        for (int k = 1; k <= 8; k++)
            step_check("dual", k, (k >= 6) ? 4'h9 : 4'h0, (k == 6) ? 4'h9 : 4'h0, 4'h0);
        bus.button[0] = 1'b0;
        bus.button[3] = 1'b0;
        for (int k = 1; k <= 8; k++)
            step_check("dual_rel", k, (k < 6) ? 4'h9 : 4'h0, 4'h0, (k == 6) ? 4'h9 : 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
